// File: rtl/affine_systolic_pe.sv
// affine_systolic_pe: Gotoh affine-gap systolic cell; tracks the best local score and the index where it occurred.
// 1-cycle latency on all outputs; no backpressure, so downstream must accept every valid_out.
module affine_systolic_pe #(
    parameter int SCORE_WIDTH  = 10,
    parameter int LETTER_WIDTH = 2,
    parameter int SOURCE_WIDTH = 2,
    parameter int IDX_WIDTH    = 10,
    parameter int MATCH        = 3,
    parameter int MISMATCH     = 3,
    parameter int GAP_OPEN     = 4,
    parameter int GAP_EXTEND   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_query,
    input  logic [LETTER_WIDTH-1:0] query_in,
    input  logic                    start,
    input  logic                    valid_in,
    input  logic [LETTER_WIDTH-1:0] db_in,
    input  logic [SCORE_WIDTH-1:0]  h_in,
    input  logic [SCORE_WIDTH-1:0]  f_in,
    output logic                    valid_out,
    output logic [LETTER_WIDTH-1:0] db_out,
    output logic [SCORE_WIDTH-1:0]  h_out,
    output logic [SCORE_WIDTH-1:0]  f_out,
    output logic [SOURCE_WIDTH-1:0] source,
    output logic                    zero_score_bit,
    output logic [SCORE_WIDTH-1:0]  best_score,
    output logic [IDX_WIDTH-1:0]    best_idx
);

    typedef logic [SCORE_WIDTH:0]   ext_t;
    typedef logic [SCORE_WIDTH-1:0] score_t;

    localparam score_t                  SCORE_MAX = '1;
    localparam logic [IDX_WIDTH-1:0]    IDX_MAX   = '1;
    localparam logic [IDX_WIDTH-1:0]    IDX_ONE   = {{(IDX_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SOURCE_WIDTH-1:0] SRC_ZERO  = SOURCE_WIDTH'(0);
    localparam logic [SOURCE_WIDTH-1:0] SRC_DIAG  = SOURCE_WIDTH'(1);
    localparam logic [SOURCE_WIDTH-1:0] SRC_TOP   = SOURCE_WIDTH'(2);
    localparam logic [SOURCE_WIDTH-1:0] SRC_LEFT  = SOURCE_WIDTH'(3);

    // The sign bit of the widened difference marks an underflow, which floors to zero.
    function automatic score_t sub_floor(input score_t a, input ext_t b);
        ext_t d;
        d = {1'b0, a} - b;
        return d[SCORE_WIDTH] ? '0 : d[SCORE_WIDTH-1:0];
    endfunction

    function automatic score_t max2(input score_t a, input score_t b);
        return (a >= b) ? a : b;
    endfunction

    logic [LETTER_WIDTH-1:0] r_query;
    score_t                  r_h_prev;
    score_t                  r_e_prev;
    score_t                  r_diag;
    logic [IDX_WIDTH-1:0]    r_idx;
    score_t                  r_best;
    logic [IDX_WIDTH-1:0]    r_best_idx;
    logic                    r_valid;
    logic [LETTER_WIDTH-1:0] r_db;
    score_t                  r_h;
    score_t                  r_f;
    logic [SOURCE_WIDTH-1:0] r_src;
    logic                    r_zero;

    // start clears state ahead of the cell computed in the same cycle.
    score_t               w_h_prev;
    score_t               w_e_prev;
    score_t               w_diag;
    logic [IDX_WIDTH-1:0] w_idx;
    score_t               w_best;
    logic [IDX_WIDTH-1:0] w_best_idx;
    ext_t                 w_sum;
    score_t               w_d;
    score_t               w_e;
    score_t               w_f;
    score_t               w_h;
    logic [SOURCE_WIDTH-1:0] w_src;

    assign w_h_prev   = start ? '0 : r_h_prev;
    assign w_e_prev   = start ? '0 : r_e_prev;
    assign w_diag     = start ? '0 : r_diag;
    assign w_idx      = start ? '0 : r_idx;
    assign w_best     = start ? '0 : r_best;
    assign w_best_idx = start ? '0 : r_best_idx;

    assign w_sum = {1'b0, w_diag} + ext_t'(MATCH);
    assign w_e   = max2(sub_floor(w_h_prev, ext_t'(GAP_OPEN)), sub_floor(w_e_prev, ext_t'(GAP_EXTEND)));
    assign w_f   = max2(sub_floor(h_in, ext_t'(GAP_OPEN)), sub_floor(f_in, ext_t'(GAP_EXTEND)));
    assign w_d   = (r_query == db_in) ? (w_sum[SCORE_WIDTH] ? SCORE_MAX : w_sum[SCORE_WIDTH-1:0])
                                      : sub_floor(w_diag, ext_t'(MISMATCH));
    assign w_h   = max2(w_d, max2(w_f, w_e));

    always_comb begin
        w_src = SRC_LEFT;
        if (w_h == '0)       w_src = SRC_ZERO;
        else if (w_h == w_d) w_src = SRC_DIAG;
        else if (w_h == w_f) w_src = SRC_TOP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_query    <= '0;
            r_h_prev   <= '0;
            r_e_prev   <= '0;
            r_diag     <= '0;
            r_idx      <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_valid    <= 1'b0;
            r_db       <= '0;
            r_h        <= '0;
            r_f        <= '0;
            r_src      <= '0;
            r_zero     <= 1'b0;
        end else begin
            if (load_query) r_query <= query_in;
            r_valid <= valid_in;
            if (valid_in) begin
                r_db     <= db_in;
                r_h      <= w_h;
                r_f      <= w_f;
                r_src    <= w_src;
                r_zero   <= (w_h == '0);
                r_h_prev <= w_h;
                r_e_prev <= w_e;
                r_diag   <= h_in;
                r_idx    <= (w_idx == IDX_MAX) ? w_idx : w_idx + IDX_ONE;
                if (w_h > w_best) begin
                    r_best     <= w_h;
                    r_best_idx <= w_idx;
                end else begin
                    r_best     <= w_best;
                    r_best_idx <= w_best_idx;
                end
            end else if (start) begin
                r_h_prev   <= '0;
                r_e_prev   <= '0;
                r_diag     <= '0;
                r_idx      <= '0;
                r_best     <= '0;
                r_best_idx <= '0;
            end
        end
    end

    assign valid_out      = r_valid;
    assign db_out         = r_db;
    assign h_out          = r_h;
    assign f_out          = r_f;
    assign source         = r_src;
    assign zero_score_bit = r_zero;
    assign best_score     = r_best;
    assign best_idx       = r_best_idx;

endmodule

// File: tb/tb_affine_systolic_pe.sv
// Directed table-driven bench for affine_systolic_pe; expected values are hand-computed.
module tb_affine_systolic_pe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_query = 1'b0;
    logic [1:0] query_in = '0;
    logic       start = 1'b0;
    logic       valid_in = 1'b0;
    logic [1:0] db_in = '0;
    logic [9:0] h_in = '0;
    logic [9:0] f_in = '0;
    logic       valid_out;
    logic [1:0] db_out;
    logic [9:0] h_out;
    logic [9:0] f_out;
    logic [1:0] source;
    logic       zero_score_bit;
    logic [9:0] best_score;
    logic [9:0] best_idx;

    int n_cmp = 0;
    int n_bad = 0;

    affine_systolic_pe dut (
        .clk(clk), .rst(rst), .load_query(load_query), .query_in(query_in),
        .start(start), .valid_in(valid_in), .db_in(db_in), .h_in(h_in), .f_in(f_in),
        .valid_out(valid_out), .db_out(db_out), .h_out(h_out), .f_out(f_out),
        .source(source), .zero_score_bit(zero_score_bit),
        .best_score(best_score), .best_idx(best_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st, lq, qi, vi, db, hi, fi;
        int e_vo, e_db, e_h, e_f, e_src, e_z, e_best, e_idx;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string nm, input int row, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %0d expected %0d", nm, row, act, exp);
        end
    endtask

    task automatic chk_all(input int row, input int vo, input int db, input int h, input int f,
                           input int src, input int z, input int best, input int idx);
        chk("valid_out", row, int'(valid_out), vo);
        chk("db_out", row, int'(db_out), db);
        chk("h_out", row, int'(h_out), h);
        chk("f_out", row, int'(f_out), f);
        chk("source", row, int'(source), src);
        chk("zero_score_bit", row, int'(zero_score_bit), z);
        chk("best_score", row, int'(best_score), best);
        chk("best_idx", row, int'(best_idx), idx);
    endtask

    task automatic randomize_inputs();
        load_query = 1'($urandom_range(0, 1));
        query_in   = 2'($urandom_range(0, 3));
        start      = 1'($urandom_range(0, 1));
        valid_in   = 1'($urandom_range(0, 1));
        db_in      = 2'($urandom_range(0, 3));
        h_in       = 10'($urandom_range(0, 1023));
        f_in       = 10'($urandom_range(0, 1023));
    endtask

    initial begin
        //            st lq qi vi db   hi   fi | vo db  h     f    src z best  idx
        vecs[0]  = '{0, 0, 0, 0, 0,   0,   0,   0, 0,    0,    0, 0, 0,    0, 0};
        vecs[1]  = '{1, 0, 0, 1, 0,   0,   0,   1, 0,    3,    0, 1, 0,    3, 0};
        vecs[2]  = '{0, 0, 0, 1, 1,   5,   0,   1, 1,    1,    1, 2, 0,    3, 0};
        vecs[3]  = '{0, 0, 0, 1, 0,   0,   3,   1, 0,    8,    2, 1, 0,    8, 2};
        vecs[4]  = '{0, 0, 0, 0, 3,  77,  99,   0, 0,    8,    2, 1, 0,    8, 2};
        vecs[5]  = '{0, 0, 0, 0, 2, 500,   1,   0, 0,    8,    2, 1, 0,    8, 2};
        vecs[6]  = '{0, 0, 0, 0, 1,   3, 600,   0, 0,    8,    2, 1, 0,    8, 2};
        vecs[7]  = '{0, 0, 0, 1, 0,   6,   0,   1, 0,    4,    2, 3, 0,    8, 2};
        vecs[8]  = '{1, 0, 0, 1, 1,   0,   0,   1, 1,    0,    0, 0, 1,    0, 0};
        vecs[9]  = '{0, 0, 0, 1, 1, 1023,  0,   1, 1, 1019, 1019, 2, 0, 1019, 1};
        vecs[10] = '{0, 0, 0, 1, 0,   2,   0,   1, 0, 1023,    0, 1, 0, 1023, 2};
        vecs[11] = '{1, 0, 0, 1, 0,   2,   0,   1, 0,    3,    0, 1, 0,    3, 0};
        vecs[12] = '{0, 0, 0, 1, 1,   0,   0,   1, 1,    0,    0, 0, 1,    3, 0};
        vecs[13] = '{0, 0, 0, 1, 0,   1,   9,   1, 0,    8,    8, 2, 0,    8, 2};
        vecs[14] = '{0, 0, 0, 1, 0,   8,   5,   1, 0,    4,    4, 1, 0,    8, 2};
        vecs[15] = '{0, 1, 1, 1, 1,  12,   0,   1, 1,    8,    8, 2, 0,    8, 2};
        vecs[16] = '{0, 0, 0, 1, 1,   0,   0,   1, 1,   15,    0, 1, 0,   15, 5};
        vecs[17] = '{0, 0, 0, 0, 2,   9,   9,   0, 1,   15,    0, 1, 0,   15, 5};

        // Reset with random inputs driven; rst must override everything.
        for (int c = 0; c < 3; c++) begin
            rst = 1'b1;
            randomize_inputs();
            @(posedge clk);
            #1;
            chk_all(100 + c, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            start      = 1'(vecs[i].st);
            load_query = 1'(vecs[i].lq);
            query_in   = 2'(vecs[i].qi);
            valid_in   = 1'(vecs[i].vi);
            db_in      = 2'(vecs[i].db);
            h_in       = 10'(vecs[i].hi);
            f_in       = 10'(vecs[i].fi);
            @(posedge clk);
            #1;
            chk_all(i, vecs[i].e_vo, vecs[i].e_db, vecs[i].e_h, vecs[i].e_f,
                    vecs[i].e_src, vecs[i].e_z, vecs[i].e_best, vecs[i].e_idx);
        end

        // Reset mid-sequence drops all state, including the query letter (was 1).
        rst = 1'b1;
        randomize_inputs();
        @(posedge clk);
        #1;
        chk_all(200, 0, 0, 0, 0, 0, 0, 0, 0);
        rst        = 1'b0;
        load_query = 1'b0;
        start      = 1'b1;
        valid_in   = 1'b1;
        db_in      = 2'd0;
        h_in       = 10'd0;
        f_in       = 10'd0;
        @(posedge clk);
        #1;
        chk_all(201, 1, 0, 3, 0, 1, 0, 3, 0);

        // start without a valid cell clears best tracking but holds data outputs.
        start    = 1'b1;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        chk_all(202, 0, 0, 3, 0, 1, 0, 0, 0);
        start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/affine_systolic_pe.md
Name: affine_systolic_pe

Overview:
- Registered, affine-gap (Gotoh) successor to the single-cell processing element, for use in a linear systolic array.
- Each instance holds one query letter and processes one database letter per valid cycle.
- It keeps its own left-neighbour state (H, E) and diagonal internally, and forwards H/F/letter downstream with 1-cycle latency.
- It tracks the best local score and the database index at which that score occurred.

Parameters:
- SCORE_WIDTH, 10, width of H/E/F scores; unsigned.
- LETTER_WIDTH, 2, letter encoding width.
- SOURCE_WIDTH, 2, traceback source code width.
- IDX_WIDTH, 10, database index counter width.
- MATCH, 3, added on letter match.
- MISMATCH, 3, subtracted on mismatch.
- GAP_OPEN, 4, penalty for opening a gap from H.
- GAP_EXTEND, 1, penalty for extending an existing gap.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- load_query  in  1  capture query_in into the query register.
- query_in  in  LETTER_WIDTH  query letter for this PE.
- start  in  1  begin a new database sequence; clears alignment state.
- valid_in  in  1  db_in/h_in/f_in are valid this cycle.
- db_in  in  LETTER_WIDTH  database letter from upstream.
- h_in  in  SCORE_WIDTH  upstream H for the same database letter (top).
- f_in  in  SCORE_WIDTH  upstream vertical-gap score F.
- valid_out  out  1  registered copy of valid_in.
- db_out  out  LETTER_WIDTH  forwarded database letter.
- h_out  out  SCORE_WIDTH  computed H.
- f_out  out  SCORE_WIDTH  computed F.
- source  out  SOURCE_WIDTH  traceback code for h_out.
- zero_score_bit  out  1  high when h_out == 0.
- best_score  out  SCORE_WIDTH  maximum H since start.
- best_idx  out  IDX_WIDTH  database index of best_score.

Behaviour:
- Reset (rst=1 at clock edge): every output and internal register is 0. This covers query, h_prev, e_prev, diag, idx, best_score and best_idx. rst overrides all other inputs.
- load_query: query register <= query_in. Independent of valid_in. A cell computed in the same cycle uses the old query value.
- Internal state:
  - h_prev: own last H (left).
  - e_prev: own last E.
  - diag: last accepted h_in.
  - idx: count of cells processed since start.
- start=1 clears h_prev, e_prev, diag, idx, best_score and best_idx.
- start and valid_in together: the clear applies first, and the incoming cell is processed as index 0 with h_prev=e_prev=diag=0.
- All subtractions are evaluated in SCORE_WIDTH+1 bits and floor at 0. The match addition saturates at 2^SCORE_WIDTH-1.
- Cell equations, evaluated on a valid_in cycle:
  - E = max(h_prev-GAP_OPEN, e_prev-GAP_EXTEND)
  - F = max(h_in-GAP_OPEN, f_in-GAP_EXTEND)
  - D = (query==db_in) ? diag+MATCH : diag-MISMATCH
  - H = max(D, F, E), which is >= 0 by the flooring.
- Source encoding:
  - 00 = H==0.
  - 01 = DIAG, 10 = TOP (F), 11 = LEFT (E).
  - Tie priority: DIAG > TOP > LEFT.
- Registered outputs, 1-cycle latency: h_out<=H, f_out<=F, db_out<=db_in, source, zero_score_bit<=(H==0), valid_out<=1.
- State updates on the same valid cycle: h_prev<=H, e_prev<=E, diag<=h_in.
- Best tracking: if H > best_score (strict), then best_score<=H and best_idx<=idx. Ties keep the earliest index. idx<=idx+1, saturating at 2^IDX_WIDTH-1 with no wrap.
- valid_in=0: valid_out<=0. All data outputs and internal state hold (a stall bubble). No backpressure port; downstream must accept every valid_out.
- rst mid-sequence: state is lost, and the next sequence requires start.

Test Plan:
1. Reset: assert rst with random inputs driven -> all outputs 0 on the next cycle; valid_out=0.
2. Match/gap chain. Setup: defaults, query=0, start=1 on the first cycle. Drive valid cells, in order:
   - (db=0, h_in=0, f_in=0) -> h_out=3, source=01, best_score=3, best_idx=0.
   - (db=1, h_in=5, f_in=0) -> F=1, h_out=1, source=10, f_out=1.
   - (db=0, h_in=0, f_in=3) -> D=5+3=8, h_out=8, source=01, best_score=8, best_idx=2.
3. Saturation: diag=1023 (prior h_in), match -> h_out=1023; diag=2, mismatch with all other terms 0 -> h_out=0, source=00, zero_score_bit=1.
4. Stall: insert 3 idle cycles mid-sequence -> outputs hold, valid_out=0; the next valid cell's result matches the no-stall reference exactly.
5. Restart: start with valid_in mid-sequence (h_prev=8) -> cell computed with h_prev=e_prev=diag=0; best_idx=0; best_score equals this cell's H.
6. Tie and priority: D=F=E=4 -> source=01; a later equal-score cell leaves best_idx unchanged. Also drive load_query and valid_in in the same cycle -> the old query letter is used for that cell.
